data_memory_responder: RTL and testbench
========================================

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, the number of 32-bit words of storage.
REQ-002 SHALL have parameter WAIT_STATES, default 2, range 0..15, the extra cycles between accept and response.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port req_funct3  input  3  width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 SHALL have port resp_valid  output  1  response present.
REQ-012 SHALL have port resp_ready  input  1  requester accepts the response.
REQ-013 SHALL have port resp_rdata  output  32  load data, extended to 32 bits; 0 for stores and errors.
REQ-014 SHALL have port resp_error  output  1  access rejected; no storage change.

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready=1 only in IDLE; request accepted when req_valid&&req_ready.
REQ-016 SHALL latch addr, wdata, funct3 and write on accept; later input changes are ignored until the next accept.
REQ-017 SHALL load the wait counter with WAIT_STATES on accept and decrement it in WAIT; at 0, go to RESP.
REQ-018 SHALL, with WAIT_STATES=0, bypass WAIT and go from IDLE to RESP.
REQ-019 SHALL assert resp_valid exactly 1+WAIT_STATES cycles after the accept edge.
REQ-020 SHALL commit a store on the clock edge that enters RESP.
REQ-021 SHALL hold resp_valid, resp_rdata and resp_error stable in RESP until resp_ready=1.
REQ-022 SHALL return to IDLE on the edge where resp_valid&&resp_ready, with req_ready=1 the next cycle; there is no same-cycle back-to-back.
REQ-023 SHALL map bytes little-endian: word index addr[31:2], lane addr[1:0].
REQ-024 SHALL sign-extend loads for B and H, zero-extend for BU and HU, and return the full word for W.
REQ-025 SHALL, on a store, write only the addressed lane(s): B writes wdata[7:0]; H writes wdata[15:0] at lane addr[1]*2; W writes all 32 bits.
REQ-026 SHALL flag an error when the word index >= DEPTH_WORDS, funct3 is 011, 110 or 111, or a store uses funct3 100 or 101.
REQ-027 SHALL, on error, return resp_error=1 and resp_rdata=0 after the same latency, with no write.

Reset
REQ-028 SHALL, while reset=1, force state IDLE, req_ready=0, resp_valid=0, resp_error=0, resp_rdata=0 and the wait counter to 0.
REQ-029 SHALL, when reset is asserted mid-transaction, discard the pending request; a store not yet committed SHALL never be written.
REQ-030 SHALL not initialise storage contents on reset.

Configuration
REQ-031 SHALL, with macro DMEM_ALIGN_CHECK_EN defined, flag an error for H/HU when addr[0]=1 and for W when addr[1:0]!=0.
REQ-032 SHALL, with DMEM_ALIGN_CHECK_EN undefined, clear the misaligned low address bits (H: addr[0]; W: addr[1:0]) and never flag misalignment; range and funct3 errors are unchanged.

Structure
REQ-033 SHALL place the funct3 width encodings, the FSM state encoding and the wait counter width in shared package dmem_pkg.
REQ-034 SHALL put byte-lane extraction, sign/zero extension and store merge in one combinational sub-module, dmem_lane_align.

Verification
REQ-035 SHALL check: store W 0xDEADBEEF at 0x10, then load W at 0x10 -> rdata 0xDEADBEEF, error 0, resp_valid 3 cycles after accept (WAIT_STATES=2).
REQ-036 SHALL check: load B and BU at 0x13 after REQ-035 -> 0xFFFFFFDE and 0x000000DE; load HU at 0x10 -> 0x0000BEEF.
REQ-037 SHALL check: store B 0x55 at 0x11 over 0xDEADBEEF -> load W at 0x10 returns 0xDEAD55EF.
REQ-038 SHALL check: load W at 0x12 -> with DMEM_ALIGN_CHECK_EN, error 1 and rdata 0; without it, rdata 0xDEAD55EF and error 0.
REQ-039 SHALL check: store W at DEPTH_WORDS*4 -> error 1, and a subsequent load at 0x0 is unchanged; hold resp_ready=0 for 5 cycles -> response stable, req_ready stays 0.
REQ-040 SHALL check: reset asserted in WAIT during a store to 0x20 -> resp_valid 0, and a later load at 0x20 returns the old contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data memory responder:
//   - funct3_e   : access width codes carried on req_funct3
//   - state_e    : responder handshake state encoding
//   - WAIT_CNT_W : width of the wait-state down counter
//   - funct3_ok  : legality of a width code for a load or a store
// No ports (package).
// ---------------------------------------------------------------------------
package dmem_pkg;

    // Wait counter holds values 0..15.
    localparam int WAIT_CNT_W = 4;

    // Width codes. Bit 2 set means unsigned (zero-extended) load.
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    // Responder state: accept in IDLE, count latency in WAIT, present in RESP.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Signed/unsigned variants only make sense for loads; stores with
    // BU/HU and the unassigned codes are rejected.
    function automatic logic funct3_ok(input logic [2:0] f3, input logic is_store);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// ---------------------------------------------------------------------------
// dmem_lane_align
// Combinational byte-lane handling for the data memory responder.
// Extracts and extends load data from a stored word, and merges store data
// into the addressed lane(s) of that word.
// Ports:
//   funct3     in  3   access width code (dmem_pkg::funct3_e values)
//   lane       in  2   byte lane within the word, already aligned to width
//   rd_word    in  32  current contents of the addressed word
//   wdata      in  32  right-aligned store data
//   load_data  out 32  load result, sign/zero extended to 32 bits
//   store_word out 32  rd_word with the addressed lane(s) replaced
// ---------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [3:0]  byte_en;
    logic [31:0] wdata_rep;

    // Load path: pick the addressed byte/half, then extend per width code.
    // Halfwords live in lanes 0-1 or 2-3, so only lane[1] selects them.
    always_comb begin
        sel_byte  = rd_word[{lane, 3'b000} +: 8];
        sel_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'h000000, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'h0000, sel_half};
            F3_W:    load_data = rd_word;
            default: load_data = '0;
        endcase
    end

    // Store path: replicate the store data across the word so every lane
    // sees the right bits, then let the byte enables pick which lanes change.
    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = wdata;
        case (funct3)
            F3_B: begin
                byte_en   = 4'b0001 << lane;
                wdata_rep = {4{wdata[7:0]}};
            end
            F3_H: begin
                byte_en   = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            F3_W: begin
                byte_en   = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                byte_en   = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
        store_word = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                store_word[8*i +: 8] = wdata_rep[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
// Word-organised data memory behind a valid/ready request channel and a
// valid/ready response channel, with a fixed programmable latency.
// One request is in flight at a time: IDLE -> (WAIT) -> RESP -> IDLE.
// Parameters:
//   DEPTH_WORDS  number of 32-bit words of storage
//   WAIT_STATES  extra cycles between accept and response (0..15)
// Optional build macro:
//   DMEM_ALIGN_CHECK_EN  when defined, misaligned H/HU/W accesses are
//                        rejected; when undefined the low address bits are
//                        cleared instead.
// Ports:
//   clk         in  1   clock, all state updates on rising edge
//   reset       in  1   synchronous active-high reset
//   req_valid   in  1   request present
//   req_ready   out 1   responder can accept a request
//   req_write   in  1   1 = store, 0 = load
//   req_addr    in  32  byte address
//   req_wdata   in  32  store data, right-aligned
//   req_funct3  in  3   width code B/H/W/BU/HU
//   resp_valid  out 1   response present
//   resp_ready  in  1   requester accepts the response
//   resp_rdata  out 32  load data; 0 for stores and errors
//   resp_error  out 1   access rejected, storage untouched
// ---------------------------------------------------------------------------
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_e                state;
    state_e                next_state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [WAIT_CNT_W-1:0] next_wait_cnt;

    logic                  lat_write;
    logic [31:0]           lat_addr;
    logic [31:0]           lat_wdata;
    logic [2:0]            lat_funct3;

    logic                  eff_write;
    logic [31:0]           eff_addr;
    logic [31:0]           eff_wdata;
    logic [2:0]            eff_funct3;

    logic                  accept;
    logic                  enter_resp;
    logic [31:0]           word_num;
    logic                  in_range;
    logic [IDX_W-1:0]      word_idx;
    logic [1:0]            lane;
    logic                  misaligned;
    logic                  access_error;

    logic [31:0]           rd_word;
    logic [31:0]           load_data;
    logic [31:0]           store_word;
    logic [31:0]           rdata_q;
    logic                  error_q;

    logic [31:0]           mem [DEPTH_WORDS];

    assign accept     = req_valid && req_ready;
    assign enter_resp = (next_state == ST_RESP) && (state != ST_RESP);

    // The response is computed on the edge that enters RESP. With no wait
    // states that is the accept edge itself, before the latches hold the
    // request, so in IDLE the live request fields are used directly.
    always_comb begin
        if (state == ST_IDLE) begin
            eff_write  = req_write;
            eff_addr   = req_addr;
            eff_wdata  = req_wdata;
            eff_funct3 = req_funct3;
        end else begin
            eff_write  = lat_write;
            eff_addr   = lat_addr;
            eff_wdata  = lat_wdata;
            eff_funct3 = lat_funct3;
        end
    end

    // Address decode: word index from addr[31:2], lane from addr[1:0].
    // Misaligned halfword/word accesses are either rejected or forced
    // down to the containing aligned lane, depending on the build.
    always_comb begin
        word_num   = {2'b00, eff_addr[31:2]};
        in_range   = word_num < 32'(DEPTH_WORDS);
        word_idx   = eff_addr[IDX_W+1:2];
        lane       = eff_addr[1:0];
        misaligned = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        case (eff_funct3)
            F3_H, F3_HU: misaligned = eff_addr[0];
            F3_W:        misaligned = |eff_addr[1:0];
            default:     misaligned = 1'b0;
        endcase
`else
        case (eff_funct3)
            F3_H, F3_HU: lane[0] = 1'b0;
            F3_W:        lane    = 2'b00;
            default:     lane    = eff_addr[1:0];
        endcase
`endif
        access_error = !in_range || !funct3_ok(eff_funct3, eff_write) || misaligned;
    end

    // Out-of-range indices never reach the array.
    assign rd_word = in_range ? mem[word_idx] : '0;

    dmem_lane_align u_lane_align (
        .funct3     (eff_funct3),
        .lane       (lane),
        .rd_word    (rd_word),
        .wdata      (eff_wdata),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Next-state logic. The counter is loaded on accept and counts down in
    // WAIT; the edge that takes it to zero is the edge that enters RESP, so
    // the response appears in cycle 1+WAIT_STATES after the accept edge.
    always_comb begin
        next_state    = state;
        next_wait_cnt = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_wait_cnt = WAIT_CNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        next_state = ST_RESP;
                    end else begin
                        next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt <= WAIT_CNT_W'(1)) begin
                    next_wait_cnt = '0;
                    next_state    = ST_RESP;
                end else begin
                    next_wait_cnt = wait_cnt - WAIT_CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state    = ST_IDLE;
                next_wait_cnt = '0;
            end
        endcase
    end

    // State and counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait_cnt;
        end
    end

    // Capture the request on accept so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_funct3 <= '0;
        end else if (accept) begin
            lat_write  <= req_write;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            lat_funct3 <= req_funct3;
        end
    end

    // Response registers, loaded once on entry to RESP and held until the
    // handshake so the requester can stall without the data moving.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
            error_q <= 1'b0;
        end else if (enter_resp) begin
            error_q <= access_error;
            rdata_q <= (access_error || eff_write) ? 32'h0 : load_data;
        end
    end

    // Storage write. Commits only on the edge entering RESP, so a reset
    // during WAIT drops the store. Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && eff_write && !access_error) begin
            mem[word_idx] <= store_word;
        end
    end

    // Outputs are held quiet for as long as reset is high.
    always_comb begin
        req_ready  = (state == ST_IDLE) && !reset;
        resp_valid = (state == ST_RESP) && !reset;
        resp_rdata = reset ? 32'h0 : rdata_q;
        resp_error = !reset && error_q;
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_data_memory_responder
// Self-checking bench for data_memory_responder. A byte-addressed model
// supplies every expected load value, error flag and latency.
// ---------------------------------------------------------------------------
module tb_data_memory_responder;

    localparam int DEPTH = 1024;
    localparam int WAITS = 2;
    localparam int LAT   = 1 + WAITS;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

    int vectors     = 0;
    int miscompares = 0;

    bit [7:0] model_mem [int];

    always #5 clk = ~clk;

    data_memory_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (WAITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error)
    );

    // Reference model: plain byte array, little-endian, width from funct3.
    function automatic void model_access(input bit wr, input bit [31:0] addr,
                                         input bit [31:0] wdata, input bit [2:0] f3,
                                         output bit [31:0] rdata, output bit err);
        int       size;
        bit [31:0] a;
        bit [31:0] v;
        rdata = 0;
        err   = 0;
        a     = addr;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default: begin size = 1; err = 1; end
        endcase
        if (wr && f3[2]) err = 1;
        if ((addr >> 2) >= DEPTH) err = 1;
`ifdef DMEM_ALIGN_CHECK_EN
        if ((a % size) != 0) err = 1;
`else
        a = a - (a % size);
`endif
        if (err) return;
        if (wr) begin
            for (int i = 0; i < size; i++) model_mem[int'(a) + i] = wdata[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < size; i++) v = v | (32'(model_mem[int'(a) + i]) << (8 * i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 1);
            rdata = v;
        end
    endfunction

    // Drive one request, wait for its response, optionally stall, then
    // complete the handshake. Reports what was observed; callers compare.
    task automatic run_txn(input bit wr, input bit [31:0] addr, input bit [31:0] wdata,
                           input bit [2:0] f3, input int hold,
                           output bit [31:0] rdata, output bit err, output int lat,
                           output bit stable, output bit ready_during, output bit ready_after);
        bit ok;
        @(negedge clk);
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        req_valid  = 1'b1;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            if (req_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("[TB] FAIL accept_timeout addr=%h req_ready=%b required 1", addr, req_ready);
        end
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!resp_valid) begin
            vectors++; miscompares++;
            $display("[TB] FAIL resp_timeout addr=%h resp_valid=%b required 1", addr, resp_valid);
        end
        ready_during = req_ready;
        rdata  = resp_rdata;
        err    = resp_error;
        stable = 1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!resp_valid || req_ready || resp_rdata !== rdata || resp_error !== err) stable = 0;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready  = 1'b0;
        ready_after = req_ready;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_req_ready got %b want 0", req_ready); end
        vectors++;
        if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_resp_valid got %b want 0", resp_valid); end
        vectors++;
        if (resp_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_resp_rdata got %h want 0", resp_rdata); end
        vectors++;
        if (resp_error !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_resp_error got %b want 0", resp_error); end
        reset = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_req_ready got %b want 1", req_ready); end
    endtask

    task automatic test_init_region();
        bit [31:0] rd, exp_rd, d;
        bit er, exp_er, st, rdur, raft;
        int lat;
        for (int w = 0; w < 16; w++) begin
            d = $urandom;
            model_access(1'b1, 32'(w * 4), d, 3'b010, exp_rd, exp_er);
            run_txn(1'b1, 32'(w * 4), d, 3'b010, 0, rd, er, lat, st, rdur, raft);
            vectors++;
            if (er !== exp_er || lat != LAT) begin
                miscompares++;
                $display("[TB] FAIL init_store w=%0d err=%b lat=%0d want err=%b lat=%0d", w, er, lat, exp_er, LAT);
            end
        end
    endtask

    task automatic test_word_store_load();
        bit [31:0] rd, mr;
        bit er, me, st, rdur, raft;
        int lat;
        model_access(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, mr, me);
        run_txn(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, rd, er, lat, st, rdur, raft);
        vectors++;
        if (er !== 1'b0 || rd !== 32'h0) begin miscompares++; $display("[TB] FAIL store_w err=%b rdata=%h want 0/0", er, rd); end
        run_txn(1'b0, 32'h10, 32'h0, 3'b010, 0, rd, er, lat, st, rdur, raft);
        vectors++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin miscompares++; $display("[TB] FAIL load_w rdata=%h err=%b want deadbeef/0", rd, er); end
        vectors++;
        if (lat != 3) begin miscompares++; $display("[TB] FAIL load_w_latency got %0d want 3", lat); end
    endtask

    task automatic test_byte_half_load();
        bit [31:0] rd;
        bit er, st, rdur, raft;
        int lat;
        run_txn(1'b0, 32'h13, 32'h0, 3'b000, 0, rd, er, lat, st, rdur, raft);
        vectors++;
        if (rd !== 32'hFFFFFFDE || er !== 1'b0) begin miscompares++; $display("[TB] FAIL load_b rdata=%h err=%b want ffffffde/0", rd, er); end
        run_txn(1'b0, 32'h13, 32'h0, 3'b100, 0, rd, er, lat, st, rdur, raft);
        vectors++;
        if (rd !== 32'h000000DE || er !== 1'b0) begin miscompares++; $display("[TB] FAIL load_bu rdata=%h err=%b want 000000de/0", rd, er); end
        run_txn(1'b0, 32'h10, 32'h0, 3'b101, 0, rd, er, lat, st, rdur, raft);
        vectors++;
        if (rd !== 32'h0000BEEF || er !== 1'b0) begin miscompares++; $display("[TB] FAIL load_hu rdata=%h err=%b want 0000beef/0", rd, er); end
    endtask

    task automatic test_byte_store();
        bit [31:0] rd, mr;
        bit er, me, st, rdur, raft;
        int lat;
        model_access(1'b1, 32'h11, 32'h55, 3'b000, mr, me);
        run_txn(1'b1, 32'h11, 32'h55, 3'b000, 0, rd, er, lat, st, rdur, raft);
        vectors++;
        if (er !== 1'b0) begin miscompares++; $display("[TB] FAIL store_b err=%b want 0", er); end
        run_txn(1'b0, 32'h10, 32'h0, 3'b010, 0, rd, er, lat, st, rdur, raft);
        vectors++;
        if (rd !== 32'hDEAD55EF) begin miscompares++; $display("[TB] FAIL merge_b rdata=%h want dead55ef", rd); end
    endtask

    task automatic test_misaligned();
        bit [31:0] rd;
        bit er, st, rdur, raft;
        int lat;
        run_txn(1'b0, 32'h12, 32'h0, 3'b010, 0, rd, er, lat, st, rdur, raft);
        vectors++;
`ifdef DMEM_ALIGN_CHECK_EN
        if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("[TB] FAIL misaligned_w err=%b rdata=%h want 1/0", er, rd); end
`else
        if (er !== 1'b0 || rd !== 32'hDEAD55EF) begin miscompares++; $display("[TB] FAIL misaligned_w err=%b rdata=%h want 0/dead55ef", er, rd); end
`endif
        vectors++;
        if (lat != LAT) begin miscompares++; $display("[TB] FAIL misaligned_latency got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_range_hold();
        bit [31:0] rd, exp_rd;
        bit er, exp_er, st, rdur, raft;
        int lat;
        run_txn(1'b1, 32'(DEPTH * 4), 32'hA5A5A5A5, 3'b010, 5, rd, er, lat, st, rdur, raft);
        vectors++;
        if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("[TB] FAIL range_err err=%b rdata=%h want 1/0", er, rd); end
        vectors++;
        if (lat != LAT) begin miscompares++; $display("[TB] FAIL range_latency got %0d want %0d", lat, LAT); end
        vectors++;
        if (st !== 1'b1 || rdur !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_stable stable=%b req_ready=%b want 1/0", st, rdur); end
        model_access(1'b0, 32'h0, 32'h0, 3'b010, exp_rd, exp_er);
        run_txn(1'b0, 32'h0, 32'h0, 3'b010, 0, rd, er, lat, st, rdur, raft);
        vectors++;
        if (rd !== exp_rd || er !== exp_er) begin miscompares++; $display("[TB] FAIL word0_unchanged rdata=%h err=%b want %h/%b", rd, er, exp_rd, exp_er); end
    endtask

    task automatic test_reset_mid();
        bit [31:0] rd, exp_rd;
        bit er, exp_er, st, rdur, raft;
        int lat;
        model_access(1'b0, 32'h20, 32'h0, 3'b010, exp_rd, exp_er);
        @(negedge clk);
        req_write  = 1'b1;
        req_addr   = 32'h20;
        req_wdata  = ~exp_rd;
        req_funct3 = 3'b010;
        req_valid  = 1'b1;
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_reset_ready got %b want 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL mid_reset_quiet c=%0d resp_valid=%b req_ready=%b want 0/0", c, resp_valid, req_ready);
            end
        end
        reset = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_reset_idle resp_valid=%b req_ready=%b want 0/1", resp_valid, req_ready); end
        run_txn(1'b0, 32'h20, 32'h0, 3'b010, 0, rd, er, lat, st, rdur, raft);
        vectors++;
        if (rd !== exp_rd || er !== exp_er) begin miscompares++; $display("[TB] FAIL store_dropped rdata=%h err=%b want %h/%b", rd, er, exp_rd, exp_er); end
    endtask

    task automatic test_back_to_back();
        bit [31:0] rd, exp_rd, d;
        bit er, exp_er, st, rdur, raft;
        int lat;
        bit [31:0] a;
        a = 32'h2C | 32'($urandom_range(0, 1) * 2);
        d = $urandom;
        model_access(1'b1, a, d, 3'b001, exp_rd, exp_er);
        run_txn(1'b1, a, d, 3'b001, 0, rd, er, lat, st, rdur, raft);
        vectors++;
        if (rdur !== 1'b0 || raft !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_store_ready during=%b after=%b want 0/1", rdur, raft); end
        model_access(1'b0, a, 32'h0, 3'b001, exp_rd, exp_er);
        run_txn(1'b0, a, 32'h0, 3'b001, 0, rd, er, lat, st, rdur, raft);
        vectors++;
        if (rd !== exp_rd || er !== exp_er || raft !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_load rdata=%h err=%b ready_after=%b want %h/%b/1", rd, er, raft, exp_rd, exp_er);
        end
    endtask

    task automatic test_random();
        bit [31:0] rd, exp_rd, a, d;
        bit [2:0] f3;
        bit er, exp_er, st, rdur, raft, wr;
        int lat, hold, pick;
        bit [2:0] codes [5];
        codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int t = 0; t < 80; t++) begin
            wr   = 1'($urandom);
            a    = 32'($urandom_range(0, 63));
            d    = $urandom;
            pick = $urandom_range(0, 19);
            if (pick == 0) f3 = 3'($urandom_range(0, 1) ? 3 : $urandom_range(6, 7));
            else f3 = codes[$urandom_range(0, 4)];
            if (pick == 1) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 4095));
            hold = $urandom_range(0, 2);
            model_access(wr, a, d, f3, exp_rd, exp_er);
            run_txn(wr, a, d, f3, hold, rd, er, lat, st, rdur, raft);
            vectors++;
            if (rd !== exp_rd || er !== exp_er || lat != LAT || st !== 1'b1 || raft !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL random t=%0d wr=%b addr=%h f3=%0d rdata=%h err=%b lat=%0d stable=%b ready=%b want %h/%b/%0d/1/1",
                         t, wr, a, f3, rd, er, lat, st, raft, exp_rd, exp_er, LAT);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = '0;
        resp_ready = 1'b0;
        test_reset();
        test_init_region();
        test_word_store_load();
        test_byte_half_load();
        test_byte_store();
        test_misaligned();
        test_range_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1, "[TB] watchdog");
    end

endmodule
